// File: rtl/cam_pixel_capture.sv
// Camera bus capture: oversamples PCLK/HREF/VSYNC/DATA in the system clock,
// packs byte pairs into RGB565 pixels and emits linear frame-buffer writes.
module cam_pixel_capture #(
    parameter int H_ACT    = 320,
    parameter int V_ACT    = 240,
    parameter int ADDR_W   = 17,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iCamPclk,
    input  logic              iCamVsync,
    input  logic              iCamHsync,
    input  logic [7:0]        iCamData,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [15:0]       oWrData,
    output logic              oFrameDone,
    output logic [7:0]        oFrameCnt,
    output logic              oLineErr,
    output logic              oFrameErr
);

    localparam int HC_W = $clog2(H_ACT + 2);
    localparam int VC_W = $clog2(V_ACT + 2);
    // One extra address bit so a frame that exactly fills 2^ADDR_W still
    // has a representable "full" index for overflow detection.
    localparam logic [ADDR_W:0] PIX_TOT  = (ADDR_W + 1)'(H_ACT * V_ACT);
    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACT);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACT);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic              pclk_s1_d, pclk_s2_d, pclk_s3_d;
    logic              vs_s1_q, vs_s2_q, vs_s3_q;
    logic              vs_s1_d, vs_s2_d, vs_s3_d;
    logic              hs_s1_q, hs_s2_q, hs_s3_q;
    logic              hs_s1_d, hs_s2_d, hs_s3_d;
    logic [7:0]        data_s1_q, data_s2_q, data_s1_d, data_s2_d;
    logic              toggle_q, toggle_d;
    logic [7:0]        first_q, first_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [HC_W-1:0]   line_pix_q, line_pix_d;
    logic [VC_W-1:0]   line_cnt_q, line_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    logic pclk_rise, vs_rise, vs_fall, hs_fall;

    always_comb begin
        pclk_s1_d    = iCamPclk;
        pclk_s2_d    = pclk_s1_q;
        pclk_s3_d    = pclk_s2_q;
        vs_s1_d      = iCamVsync;
        vs_s2_d      = vs_s1_q;
        vs_s3_d      = vs_s2_q;
        hs_s1_d      = iCamHsync;
        hs_s2_d      = hs_s1_q;
        hs_s3_d      = hs_s2_q;
        data_s1_d    = iCamData;
        data_s2_d    = data_s1_q;

        pclk_rise    = pclk_s2_q & ~pclk_s3_q;
        vs_rise      = vs_s2_q & ~vs_s3_q;
        vs_fall      = ~vs_s2_q & vs_s3_q;
        hs_fall      = ~hs_s2_q & hs_s3_q;

        state_d      = state_q;
        toggle_d     = toggle_q;
        first_d      = first_q;
        addr_d       = addr_q;
        line_pix_d   = line_pix_q;
        line_cnt_d   = line_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (iEn && vs_rise) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d     = CAPTURE;
                    addr_d      = '0;
                    line_cnt_d  = '0;
                    line_pix_d  = '0;
                    toggle_d    = 1'b0;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (pclk_rise && hs_s2_q) begin
                    if (!toggle_q) begin
                        first_d  = data_s2_q;
                        toggle_d = 1'b1;
                    end else begin
                        toggle_d = 1'b0;
                        if (line_pix_q != '1) line_pix_d = line_pix_q + 1'b1;
                        if (addr_q == PIX_TOT) begin
                            frame_err_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q[ADDR_W-1:0];
                            wr_data_d = HI_FIRST ? {first_q, data_s2_q}
                                                 : {data_s2_q, first_q};
                            addr_d    = addr_q + 1'b1;
                        end
                    end
                end
                if (hs_fall) begin
                    toggle_d   = 1'b0;
                    line_pix_d = '0;
                    if (toggle_q || line_pix_q != H_ACT_C) line_err_d = 1'b1;
                    if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
                end
                // A malformed line also means the frame lacks V_ACT good lines.
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                    if (line_cnt_d != V_ACT_C || line_err_d) frame_err_d = 1'b1;
                    state_d = iEn ? SYNC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= IDLE;
            pclk_s1_q    <= 1'b0;
            pclk_s2_q    <= 1'b0;
            pclk_s3_q    <= 1'b0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_s3_q      <= 1'b0;
            hs_s1_q      <= 1'b0;
            hs_s2_q      <= 1'b0;
            hs_s3_q      <= 1'b0;
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            toggle_q     <= 1'b0;
            first_q      <= '0;
            addr_q       <= '0;
            line_pix_q   <= '0;
            line_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pclk_s1_q    <= pclk_s1_d;
            pclk_s2_q    <= pclk_s2_d;
            pclk_s3_q    <= pclk_s3_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_s3_q      <= vs_s3_d;
            hs_s1_q      <= hs_s1_d;
            hs_s2_q      <= hs_s2_d;
            hs_s3_q      <= hs_s3_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            toggle_q     <= toggle_d;
            first_q      <= first_d;
            addr_q       <= addr_d;
            line_pix_q   <= line_pix_d;
            line_cnt_q   <= line_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign oWrEn      = wr_en_q;
    assign oWrAddr    = wr_addr_q;
    assign oWrData    = wr_data_q;
    assign oFrameDone = frame_done_q;
    assign oFrameCnt  = frame_cnt_q;
    assign oLineErr   = line_err_q;
    assign oFrameErr  = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture: small 4x2 frame, two byte orders,
// 100 MHz system clock and a 25 MHz camera bus driven off the clock edges.
module tb_cam_pixel_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iEn = 1'b0;
    logic          pclk = 1'b0;
    logic          vs = 1'b0;
    logic          hs = 1'b0;
    logic [7:0]    cdata = 8'h00;

    logic          wr_en_a, done_a, lerr_a, ferr_a;
    logic [AW-1:0] wr_addr_a;
    logic [15:0]   wr_data_a;
    logic [7:0]    cnt_a;
    logic          wr_en_b, done_b, lerr_b, ferr_b;
    logic [AW-1:0] wr_addr_b;
    logic [15:0]   wr_data_b;
    logic [7:0]    cnt_b;

    cam_pixel_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .HI_FIRST(1'b1)) dut_a (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iCamPclk(pclk), .iCamVsync(vs),
        .iCamHsync(hs), .iCamData(cdata), .oWrEn(wr_en_a), .oWrAddr(wr_addr_a),
        .oWrData(wr_data_a), .oFrameDone(done_a), .oFrameCnt(cnt_a),
        .oLineErr(lerr_a), .oFrameErr(ferr_a));

    cam_pixel_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .HI_FIRST(1'b0)) dut_b (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iCamPclk(pclk), .iCamVsync(vs),
        .iCamHsync(hs), .iCamData(cdata), .oWrEn(wr_en_b), .oWrAddr(wr_addr_b),
        .oWrData(wr_data_b), .oFrameDone(done_b), .oFrameCnt(cnt_b),
        .oLineErr(lerr_b), .oFrameErr(ferr_b));

    always #5 iClk = ~iClk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   da;
        logic [AW-1:0] addr_b;
        logic [15:0]   db;
        logic          en_b;
    } wr_t;

    typedef struct {
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [AW-1:0] addr;
        logic [15:0]   exp_hi;
        logic [15:0]   exp_lo;
    } vec_t;

    wr_t  wq[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   fc = 0;
    int   d0 = 0;

    always @(negedge iClk) begin
        wr_t w;
        if (wr_en_a) begin
            w.addr = wr_addr_a; w.da = wr_data_a;
            w.addr_b = wr_addr_b; w.db = wr_data_b; w.en_b = wr_en_b;
            wq.push_back(w);
        end
        if (done_a) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cdata = b;
        #20 pclk = 1'b1;
        #20 pclk = 1'b0;
    endtask

    task automatic send_line(input int npix, input int base);
        hs = 1'b1;
        for (int p = 0; p < 2 * npix; p++) send_byte(8'(base + p));
        hs = 1'b0;
        #80;
    endtask

    task automatic vs_rise();
        vs = 1'b1;
        #200;
    endtask

    task automatic vs_fall();
        vs = 1'b0;
        #200;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"},  32'(wr_en_a),   0);
        chk({tag, "_addr"},  32'(wr_addr_a), 0);
        chk({tag, "_data"},  32'(wr_data_a), 0);
        chk({tag, "_done"},  32'(done_a),    0);
        chk({tag, "_cnt"},   32'(cnt_a),     0);
        chk({tag, "_lerr"},  32'(lerr_a),    0);
        chk({tag, "_ferr"},  32'(ferr_a),    0);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h01, 4'd0, 16'h0001, 16'h0100};
        vecs[1] = '{8'h02, 8'h03, 4'd1, 16'h0203, 16'h0302};
        vecs[2] = '{8'h04, 8'h05, 4'd2, 16'h0405, 16'h0504};
        vecs[3] = '{8'h06, 8'h07, 4'd3, 16'h0607, 16'h0706};
        vecs[4] = '{8'h08, 8'h09, 4'd4, 16'h0809, 16'h0908};
        vecs[5] = '{8'h0A, 8'h0B, 4'd5, 16'h0A0B, 16'h0B0A};
        vecs[6] = '{8'h0C, 8'h0D, 4'd6, 16'h0C0D, 16'h0D0C};
        vecs[7] = '{8'h0E, 8'h0F, 4'd7, 16'h0E0F, 16'h0F0E};

        // Stimulus edges land 3 ns before/after iClk edges, never on them.
        #2;
        chk_outputs_zero("reset");
        #20 iRst = 1'b0;
        iEn = 1'b1;
        #40;

        // Nominal frame, both byte orders.
        vs_rise();
        chk("idle_no_done", done_cnt, 0);
        vs_fall();
        wq.delete();
        for (int i = 0; i < 8; i++) begin
            if (i % H == 0) hs = 1'b1;
            send_byte(vecs[i].b0);
            if (i == 0) begin
                cdata = vecs[i].b1;
                #20 pclk = 1'b1;
                #20 pclk = 1'b0;
                chk("lat_pre", 32'(wr_en_a), 0);
                #6 chk("lat_pulse", 32'(wr_en_a), 1);
                #10 chk("lat_post", 32'(wr_en_a), 0);
                #4;
            end else begin
                send_byte(vecs[i].b1);
            end
            if (i % H == H - 1) begin
                hs = 1'b0;
                #80;
            end
        end
        vs_rise();
        fc = 1;
        chk("nom_nwr", wq.size(), 8);
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            chk($sformatf("nom%0d_addr", i),   32'(wq[i].addr),   32'(vecs[i].addr));
            chk($sformatf("nom%0d_hi", i),     32'(wq[i].da),     32'(vecs[i].exp_hi));
            chk($sformatf("nom%0d_addrb", i),  32'(wq[i].addr_b), 32'(vecs[i].addr));
            chk($sformatf("nom%0d_lo", i),     32'(wq[i].db),     32'(vecs[i].exp_lo));
            chk($sformatf("nom%0d_enb", i),    32'(wq[i].en_b),   1);
        end
        chk("nom_done", done_cnt, 1);
        chk("nom_cnt", 32'(cnt_a), 32'(fc));
        chk("nom_lerr", 32'(lerr_a), 0);
        chk("nom_ferr", 32'(ferr_a), 0);
        chk("nom_cnt_b", 32'(cnt_b), 32'(fc));
        chk("nom_done_b_idle", 32'(done_b), 0);
        chk("nom_lerr_b", 32'(lerr_b), 0);
        chk("nom_ferr_b", 32'(ferr_b), 0);

        // Short second line.
        vs_fall();
        wq.delete();
        send_line(4, 0);
        send_line(3, 8);
        vs_rise();
        fc = 2;
        chk("short_nwr", wq.size(), 7);
        chk("short_lerr", 32'(lerr_a), 1);
        chk("short_ferr", 32'(ferr_a), 1);
        chk("short_cnt", 32'(cnt_a), 32'(fc));
        vs_fall();
        chk("clear_lerr", 32'(lerr_a), 0);
        chk("clear_ferr", 32'(ferr_a), 0);
        wq.delete();
        send_line(4, 0);
        send_line(4, 8);
        vs_rise();
        fc = 3;
        chk("clean_nwr", wq.size(), 8);
        chk("clean_lerr", 32'(lerr_a), 0);
        chk("clean_ferr", 32'(ferr_a), 0);
        chk("clean_cnt", 32'(cnt_a), 32'(fc));

        // Overflow: one extra line.
        vs_fall();
        wq.delete();
        send_line(4, 0);
        send_line(4, 8);
        send_line(4, 16);
        chk("ovf_nwr", wq.size(), 8);
        if (wq.size() == 8) begin
            chk("ovf_last_addr", 32'(wq[7].addr), 7);
            chk("ovf_last_data", 32'(wq[7].da), 32'h0E0F);
        end
        chk("ovf_ferr", 32'(ferr_a), 1);
        chk("ovf_lerr", 32'(lerr_a), 0);
        vs_rise();
        fc = 4;
        chk("ovf_cnt", 32'(cnt_a), 32'(fc));

        // Reset in the middle of a line.
        vs_fall();
        hs = 1'b1;
        for (int p = 0; p < 4; p++) send_byte(8'(p));
        iRst = 1'b1;
        #1 chk_outputs_zero("midrst");
        fc = 0;
        #29 iRst = 1'b0;
        wq.delete();
        d0 = done_cnt;
        for (int p = 4; p < 8; p++) send_byte(8'(p));
        hs = 1'b0;
        #80;
        send_line(4, 8);
        chk("postrst_nwr", wq.size(), 0);
        vs_rise();
        chk("postrst_nodone", done_cnt - d0, 0);
        vs_fall();
        wq.delete();
        send_line(4, 0);
        send_line(4, 8);
        iEn = 1'b0;
        vs_rise();
        fc = 1;
        chk("resume_nwr", wq.size(), 8);
        if (wq.size() > 0) chk("resume_addr0", 32'(wq[0].addr), 0);
        chk("resume_cnt", 32'(cnt_a), 32'(fc));

        // Enable raised mid-frame: that frame is skipped.
        vs_fall();
        wq.delete();
        d0 = done_cnt;
        send_line(4, 0);
        iEn = 1'b1;
        send_line(4, 8);
        chk("late_en_nwr", wq.size(), 0);
        vs_rise();
        chk("late_en_nodone", done_cnt - d0, 0);
        vs_fall();
        send_line(4, 0);
        iEn = 1'b0;
        send_line(4, 8);
        vs_rise();
        fc = 2;
        chk("drop_en_nwr", wq.size(), 8);
        chk("drop_en_done", done_cnt - d0, 1);
        chk("drop_en_cnt", 32'(cnt_a), 32'(fc));
        chk("drop_en_ferr", 32'(ferr_a), 0);
        vs_fall();
        wq.delete();
        send_line(4, 0);
        send_line(4, 8);
        vs_rise();
        chk("idle_nwr", wq.size(), 0);
        chk("idle_cnt", 32'(cnt_a), 32'(fc));
        vs_fall();

        // Frame counter wrap over 256 empty frames.
        iEn = 1'b1;
        vs = 1'b1; #80;
        vs = 1'b0; #80;
        d0 = done_cnt;
        for (int k = 0; k < 256; k++) begin
            vs = 1'b1;
            #80;
            fc = (fc + 1) % 256;
            if (fc == 255) chk("wrap_255", 32'(cnt_a), 255);
            if (fc == 0)   chk("wrap_0", 32'(cnt_a), 0);
            vs = 1'b0;
            #80;
        end
        chk("wrap_final", 32'(cnt_a), 32'(fc));
        chk("wrap_done", done_cnt - d0, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
Upstream capture stage in front of the input-buffer controller. It oversamples the camera's PCLK/HSYNC/VSYNC/DATA bus in the 100 MHz system clock domain, packs byte pairs into RGB565 pixels, and emits linear frame-buffer write strobes. Outputs are `oWrEn`/`oWrAddr`/`oWrData`, which drive the buffer's `i_wr_en`/`i_wr_addr`/`i_wr_data`. It also reports frame-done, frame count and framing errors.

Parameters:
H_ACT, 320, active pixels per line
V_ACT, 240, active lines per frame
ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT
HI_FIRST, 1, 1 = first byte of a pair is pixel[15:8]; 0 = first byte is pixel[7:0]

Ports:
iClk  in  1  system clock, 100 MHz; the only clock
iRst  in  1  asynchronous, active-high reset
iEn  in  1  capture enable, level
iCamPclk  in  1  camera pixel clock, treated as asynchronous data
iCamVsync  in  1  camera VSYNC, high = vertical blanking
iCamHsync  in  1  camera HREF, high = active byte
iCamData  in  8  camera byte
oWrEn  out  1  one-cycle pixel write strobe
oWrAddr  out  ADDR_W  pixel address, 0..H_ACT*V_ACT-1
oWrData  out  16  RGB565 pixel
oFrameDone  out  1  one-cycle pulse at end of a captured frame
oFrameCnt  out  8  completed-frame counter, wraps 255->0
oLineErr  out  1  sticky: a line did not contain exactly H_ACT pixels or ended on an odd byte; cleared at frame start
oFrameErr  out  1  sticky: a frame did not contain exactly V_ACT lines, or an overflow occurred; cleared at frame start

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and all counters and synchroniser flops are 0.
- Synchronisation:
  - PCLK, VSYNC and HSYNC each pass through 2 flops; DATA passes through 2 flops in lockstep, so it stays aligned.
  - A third PCLK flop feeds edge detection: pclk_rise = s2 & ~s3.
  - iClk must run at >= 4x PCLK; the bench uses 100 MHz iClk and 25 MHz PCLK.
- Byte sampling: bytes are taken only on a pclk_rise cycle with synced HSYNC=1 and the FSM in CAPTURE. A byte toggle selects first/second byte.
- Write strobe and address:
  - oWrEn pulses exactly 1 iClk after the pclk_rise that captured the second byte.
  - oWrData = {first,second} if HI_FIRST=1, otherwise {second,first}.
  - oWrAddr = pixel index within the frame, starting at 0 and incrementing by 1 after each write.
- Overflow: once the index reaches H_ACT*V_ACT, further writes are suppressed (oWrEn stays 0), oFrameErr is set, and the address does not wrap.
- Line end: detected on the synced HSYNC falling edge.
  - The byte toggle is reset.
  - If the toggle was odd, or the line's pixel count != H_ACT, oLineErr is set.
  - The line counter increments and the per-line pixel counter clears.
- FSM:
  - IDLE -> SYNC when iEn=1 and a synced VSYNC rising edge is seen.
  - SYNC -> CAPTURE on the VSYNC falling edge. On entry to CAPTURE: address=0, line=0, toggle=0, oLineErr=0, oFrameErr=0.
  - CAPTURE -> on VSYNC rising edge:
    - oFrameDone pulses for 1 cycle and oFrameCnt increments.
    - If line count != V_ACT, oFrameErr is set.
    - Then go to SYNC if iEn=1, otherwise IDLE.
- iEn handling: iEn is evaluated only at frame boundaries. Deasserting it mid-frame lets the current frame complete.
- Entering mid-frame: a frame that is already active (VSYNC low) when leaving IDLE is never captured; capture always waits for a full VSYNC pulse.
- Reset mid-frame: capture aborts immediately, no further oWrEn, and the block returns to IDLE.
- Simultaneous events: a VSYNC rise in the same cycle as a pending second-byte write still issues that write before the frame closes.

Test Plan:
- Nominal frame (H_ACT=4, V_ACT=2, HI_FIRST=1, 25 MHz PCLK): VSYNC pulse, then 2 lines of bytes 0x00..0x0F, then VSYNC.
  - Expect 8 oWrEn at addresses 0..7 with data 0x0001, 0x0203 … 0x0E0F.
  - Expect oFrameDone=1 once, oFrameCnt=1, and both error flags 0.
- Byte order: same stimulus with HI_FIRST=0 -> first write data 0x0100, last 0x0F0E.
- Short line: line 1 carries only 3 pixels -> oLineErr=1 and oFrameErr=1 after the frame; both clear at the next frame start; the next clean frame ends with both flags 0.
- Overflow and reset:
  - A third extra line of 4 pixels -> writes stop after address 7 and oFrameErr=1.
  - Asserting iRst mid-line -> all outputs 0 immediately.
  - With iEn=1 after release, no writes occur until a new VSYNC rise/fall.
- Enable and counter wrap:
  - Raise iEn while VSYNC is low in mid-frame -> that frame is ignored and capture begins at the following frame.
  - Drop iEn mid-frame -> that frame completes and the FSM goes to IDLE.
  - Run 256 frames -> oFrameCnt wraps 255 -> 0.
